regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Write-side front end of the processor's 32×32 register file. It merges the single-cycle ALU writeback stream and the variable-latency load writeback stream into the register file's single write port (`rg_wrt_en` / `rg_wrt_addr` / `rg_wrt_data`). Load results are held in a small in-order queue that drains only in cycles when the ALU is not writing. A younger ALU write to the same destination kills any stale queued load. The block also exports a pending-write scoreboard to the hazard logic.

## Interface
- `DEPTH`, default 4: load queue entries, power of two, minimum 2.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low; sampled on `posedge clk`.
- `alu_wb_valid`  in  1  ALU result valid this cycle; there is no backpressure.
- `alu_wb_addr`  in  5  ALU destination register.
- `alu_wb_data`  in  32  ALU result.
- `ld_wb_valid`  in  1  load result offered.
- `ld_wb_ready`  out  1  queue can accept; a transfer occurs when valid && ready.
- `ld_wb_addr`  in  5  load destination register.
- `ld_wb_data`  in  32  load result.
- `rg_wrt_en`  out  1  register-file write enable (registered).
- `rg_wrt_addr`  out  5  register-file write address (registered).
- `rg_wrt_data`  out  32  register-file write data (registered).
- `pending_mask`  out  32  bit i = 1 while a live queued load targets register i.
- `q_count`  out  $clog2(DEPTH)+1  occupancy, counting both live and dead entries.

## Operation
- **Arbitration per cycle:**
  - If `alu_wb_valid` is high and `alu_wb_addr` is nonzero, the ALU wins the write port.
  - Otherwise, if the queue is non-empty, the head entry is popped.
  - If the popped head is live, it is written. If it is dead, it is discarded with no write, but the pop still consumes the cycle.
- **Load accept:**
  - `ld_wb_ready = (q_count < DEPTH)`, computed from registered state only.
  - An accepted load with address 0 is dropped and never enqueued.
- **Kill rule (ALU is always younger):**
  - An ALU write to A ≠ 0 marks every queued entry with address A as dead.
  - A load to address A accepted in the same cycle is also dropped.
- **x0:** `rg_wrt_en` never asserts with `rg_wrt_addr` = 0. An ALU write to x0 leaves the port free for the queue in that cycle.
- **Simultaneous push and pop:** permitted; `q_count` is unchanged.
- **Pointer wrap:** modulo DEPTH. Full and empty are distinguished by `q_count`.
- **`pending_mask`:** OR over live entries of the one-hot of the entry address; registered.
- **Write ordering:** no write is reordered among live entries; the queue is strictly FIFO.

## Timing
- ALU valid at cycle t → `rg_wrt_*` asserted at t+1.
- Load accepted at t into an empty queue with the ALU idle at t+1 → written at t+2. Each ALU-busy cycle adds one cycle of delay.
- `pending_mask` bit:
  - sets in the cycle after accept;
  - clears in the cycle after pop or kill.
- `ld_wb_ready`:
  - deasserts the cycle after the DEPTH-th entry is accepted;
  - reasserts the cycle after a pop.
- **Reset (`reset` low at a clock edge):**
  - `rg_wrt_en`, `rg_wrt_addr`, `rg_wrt_data` = 0.
  - `pending_mask` = 0, `q_count` = 0, `ld_wb_ready` = 0 while reset is held.
  - Queue is flushed.
  - Reset asserted mid-drain discards all queued entries; no write issues in the cycle after the reset edge.
- `ld_wb_ready` = 1 in the first cycle after reset is released.

## Structure
- **Shared package `wb_pkg`:**
  - `WB_DEPTH_DEFAULT` = 4.
  - `wb_entry_t` = {live (1), addr (5), data (32)}.
  - `REG_ZERO` = 5'd0.
- **Sub-module `wb_fifo`:**
  - DEPTH entries of `wb_entry_t` with push/pop, count, and a per-entry kill-by-address input.
  - Provides a `live_mask` output from which `pending_mask` is built.
- **Top level:** arbitration, x0 filtering, and the output registers.

## Test plan
- **Reset:** hold `reset` = 0 for 3 cycles with random inputs → every output is 0. Release → `ld_wb_ready` = 1 and `q_count` = 0.
- **ALU only:** ALU writes x5 = 0xDEADBEEF at t → at t+1 `rg_wrt_en` = 1, addr 5, data 0xDEADBEEF. An ALU write to x0 → `rg_wrt_en` stays 0.
- **Queue fill and drain:**
  - Hold ALU busy (x1..x4) while offering 5 loads to x10..x14.
  - `ld_wb_ready` drops after 4 accepts and `q_count` = 4.
  - Idle the ALU → x10..x13 are written on consecutive cycles, then x14 is accepted and written.
- **Kill:**
  - Queue a load to x7 = 0x11.
  - ALU writes x7 = 0x22 before the drain.
  - Only 0x22 reaches x7; `pending_mask`[7] clears one cycle later; the dead entry's pop cycle shows `rg_wrt_en` = 0.
- **Same-cycle conflict:** a load and an ALU write both to x9 at t → only the ALU data is written at t+1, and `pending_mask`[9] never sets.
- **Reset mid-drain:** 3 live entries queued, `reset` = 0 for 1 cycle → no further writes, `q_count` = 0, `pending_mask` = 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback path.
package wb_pkg;

  localparam int         WB_DEPTH_DEFAULT = 4;
  localparam logic [4:0] REG_ZERO         = 5'd0;

  typedef struct packed {
    logic        live;
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_entry_t;

  function automatic logic [31:0] reg_onehot(input logic [4:0] addr);
    reg_onehot = 32'd1 << addr;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order load writeback queue with per-entry kill-by-address and a
// register-indexed mask of the destinations still live in the queue.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  wb_entry_t     push_entry,
  input  logic          pop,
  output wb_entry_t     head,
  input  logic          kill_en,
  input  logic [4:0]    kill_addr,
  output logic [CW-1:0] count,
  output logic [31:0]   live_mask
);

  wb_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  assign head = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // NOTE: only the live bits need a reset; data and address of an entry
      // are meaningless until it is pushed, so the storage stays reset-free.
      for (int i = 0; i < DEPTH; i++) mem[i].live <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && mem[i].addr == kill_addr) mem[i].live <= 1'b0;
      end
      if (pop) begin
        mem[rd_ptr].live <= 1'b0;
        rd_ptr           <= rd_ptr + 1'b1;
      end
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Free slots always carry live = 0, so no occupancy qualification is needed.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    live_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i].live) live_mask = live_mask | reg_onehot(mem[i].addr);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and load writebacks onto the register file's single write port;
// the ALU always wins, queued loads drain in ALU-free cycles.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_wb_valid,
  input  logic [4:0]               alu_wb_addr,
  input  logic [31:0]              alu_wb_data,
  input  logic                     ld_wb_valid,
  output logic                     ld_wb_ready,
  input  logic [4:0]               ld_wb_addr,
  input  logic [31:0]              ld_wb_data,
  output logic                     rg_wrt_en,
  output logic [4:0]               rg_wrt_addr,
  output logic [31:0]              rg_wrt_data,
  output logic [31:0]              pending_mask,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic      out_of_reset;
  logic      alu_win;
  logic      pop;
  logic      push;
  wb_entry_t push_entry;
  wb_entry_t head;
  logic [31:0] live_mask;

  // Ready is gated by a registered flag so it stays low while reset is held.
  assign ld_wb_ready = out_of_reset && (q_count < DEPTH_C);

  assign alu_win = alu_wb_valid && (alu_wb_addr != REG_ZERO);
  assign pop     = !alu_win && (q_count != '0);

  // A same-cycle load to the ALU's destination is already stale.
  assign push = ld_wb_valid && ld_wb_ready && (ld_wb_addr != REG_ZERO) &&
                !(alu_win && ld_wb_addr == alu_wb_addr);

  assign push_entry = '{live: 1'b1, addr: ld_wb_addr, data: ld_wb_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .kill_en    (alu_win),
    .kill_addr  (alu_wb_addr),
    .count      (q_count),
    .live_mask  (live_mask)
  );

  assign pending_mask = live_mask;

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_of_reset <= 1'b0;
      rg_wrt_en    <= 1'b0;
      rg_wrt_addr  <= '0;
      rg_wrt_data  <= '0;
    end else begin
      out_of_reset <= 1'b1;
      if (alu_win) begin
        rg_wrt_en   <= 1'b1;
        rg_wrt_addr <= alu_wb_addr;
        rg_wrt_data <= alu_wb_data;
      end else if (pop && head.live) begin
        rg_wrt_en   <= 1'b1;
        rg_wrt_addr <= head.addr;
        rg_wrt_data <= head.data;
      end else begin
        // Dead pops and idle cycles leave the port quiet.
        rg_wrt_en   <= 1'b0;
        rg_wrt_addr <= '0;
        rg_wrt_data <= '0;
      end
    end
  end

endmodule
